draw_sequencer: RTL and testbench

Frame-draw scheduler for the snake game's 160x120 VGA output. On each frame request, it first runs the fill-screen engine to clear the screen to the background colour. It then plots every snake segment as a 4x4-pixel cell, and finally plots the food cell. It is the single owner of the VGA adapter's plot port: it muxes the fill engine's pixel stream during the clear phase and drives its own pixel stream afterwards.

---
 rtl/draw_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_draw_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// Frame-draw scheduler: clears the screen through the fill engine, then plots every
// snake segment and the food as 4x4-pixel cells on the single VGA plot port.
module draw_sequencer #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_frame_req,
  output logic                       o_frame_done,
  output logic                       o_busy,
  input  logic [2:0]                 i_bg_colour,
  input  logic [2:0]                 i_snake_colour,
  input  logic [2:0]                 i_food_colour,
  input  logic [4:0]                 i_snake_len,
  input  logic [5:0]                 i_food_x,
  input  logic [4:0]                 i_food_y,
  output logic [$clog2(MAX_LEN)-1:0] o_seg_addr,
  input  logic [5:0]                 i_seg_x,
  input  logic [4:0]                 i_seg_y,
  output logic                       o_fill_start,
  output logic [2:0]                 o_fill_colour,
  input  logic                       i_fill_done,
  input  logic [7:0]                 i_fill_x,
  input  logic [6:0]                 i_fill_y,
  input  logic [2:0]                 i_fill_colour,
  input  logic                       i_fill_plot,
  output logic [7:0]                 o_vga_x,
  output logic [6:0]                 o_vga_y,
  output logic [2:0]                 o_vga_colour,
  output logic                       o_vga_plot
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  // Index must be able to reach MAX_LEN itself for the end-of-list compare.
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CLEAR     = 3'd1;
  localparam logic [2:0] ST_CLEAR_END = 3'd2;
  localparam logic [2:0] ST_SEG_FETCH = 3'd3;
  localparam logic [2:0] ST_SEG_PLOT  = 3'd4;
  localparam logic [2:0] ST_FOOD_PLOT = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  logic [2:0]    r_state;
  logic [LW-1:0] r_idx;
  logic [LW-1:0] r_len;
  logic [3:0]    r_cnt;
  logic [5:0]    r_cell_x;
  logic [4:0]    r_cell_y;
  logic [2:0]    r_cell_col;
  logic [2:0]    r_bg_col;
  logic [2:0]    r_snake_col;
  logic [2:0]    r_food_col;
  logic [5:0]    r_food_x;
  logic [4:0]    r_food_y;
  logic [AW-1:0] r_seg_addr;
  logic [7:0]    r_vga_x;
  logic [6:0]    r_vga_y;
  logic [2:0]    r_vga_col;
  logic          r_vga_plot;

  logic [2:0]    w_state_d;
  logic [LW-1:0] w_idx_d;
  logic [3:0]    w_cnt_d;
  logic [5:0]    w_cell_x_d;
  logic [4:0]    w_cell_y_d;
  logic [2:0]    w_cell_col_d;
  logic          w_emit;
  logic          w_to_food;
  logic          w_start;
  logic          w_clear;
  logic          w_in_range;

  assign w_start = (r_state == ST_IDLE) && i_frame_req;

  // Next-state logic. w_cnt_d/w_cell_*_d describe the pixel shown in the next
  // cycle, so the registered pixel lines up with the plot state it belongs to.
  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_cnt_d      = r_cnt;
    w_cell_x_d   = r_cell_x;
    w_cell_y_d   = r_cell_y;
    w_cell_col_d = r_cell_col;
    w_emit       = 1'b0;
    w_to_food    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_req) begin
          w_state_d = ST_CLEAR;
          w_idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (i_fill_done) w_state_d = ST_CLEAR_END;
      end
      ST_CLEAR_END: begin
        if (!i_fill_done) begin
          if (r_len == '0) w_to_food = 1'b1;
          else             w_state_d = ST_SEG_FETCH;
        end
      end
      ST_SEG_FETCH: begin
        // Segment memory data for r_seg_addr is sampled at the end of this cycle.
        w_state_d    = ST_SEG_PLOT;
        w_cnt_d      = '0;
        w_cell_x_d   = i_seg_x;
        w_cell_y_d   = i_seg_y;
        w_cell_col_d = r_snake_col;
        w_emit       = 1'b1;
      end
      ST_SEG_PLOT: begin
        if (r_cnt == 4'd15) begin
          w_idx_d = r_idx + LW'(1);
          if (w_idx_d < r_len) w_state_d = ST_SEG_FETCH;
          else                 w_to_food = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
          w_emit  = 1'b1;
        end
      end
      ST_FOOD_PLOT: begin
        if (r_cnt == 4'd15) begin
          w_state_d = ST_DONE;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
          w_emit  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!i_frame_req) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
    if (w_to_food) begin
      w_state_d    = ST_FOOD_PLOT;
      w_cnt_d      = '0;
      w_cell_x_d   = r_food_x;
      w_cell_y_d   = r_food_y;
      w_cell_col_d = r_food_col;
      w_emit       = 1'b1;
    end
  end

  assign w_in_range = (w_cell_x_d < 6'd40) && (w_cell_y_d < 5'd30);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_cell_x    <= '0;
      r_cell_y    <= '0;
      r_cell_col  <= '0;
      r_bg_col    <= '0;
      r_snake_col <= '0;
      r_food_col  <= '0;
      r_food_x    <= '0;
      r_food_y    <= '0;
      r_seg_addr  <= '0;
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_col   <= '0;
      r_vga_plot  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_cnt      <= w_cnt_d;
      r_cell_x   <= w_cell_x_d;
      r_cell_y   <= w_cell_y_d;
      r_cell_col <= w_cell_col_d;
      if (w_start) begin
        r_bg_col    <= i_bg_colour;
        r_snake_col <= i_snake_colour;
        r_food_col  <= i_food_colour;
        r_food_x    <= i_food_x;
        r_food_y    <= i_food_y;
        r_len       <= ({27'd0, i_snake_len} > MAX_LEN) ? LW'(MAX_LEN) : LW'(i_snake_len);
        r_seg_addr  <= '0;
      end else if (w_state_d == ST_SEG_FETCH) begin
        r_seg_addr <= w_idx_d[AW-1:0];
      end
      r_vga_x    <= {w_cell_x_d, 2'b00} + {6'd0, w_cnt_d[1:0]};
      r_vga_y    <= {w_cell_y_d, 2'b00} + {5'd0, w_cnt_d[3:2]};
      r_vga_col  <= w_cell_col_d;
      r_vga_plot <= w_emit && w_in_range;
    end
  end

  assign w_clear       = (r_state == ST_CLEAR);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_frame_done  = (r_state == ST_DONE);
  assign o_fill_start  = w_clear;
  assign o_fill_colour = r_bg_col;
  assign o_seg_addr    = r_seg_addr;

  // The fill engine owns the plot port for the whole clear phase, unregistered.
  assign o_vga_x      = w_clear ? i_fill_x      : r_vga_x;
  assign o_vga_y      = w_clear ? i_fill_y      : r_vga_y;
  assign o_vga_colour = w_clear ? i_fill_colour : r_vga_col;
  assign o_vga_plot   = w_clear ? i_fill_plot   : r_vga_plot;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: stub fill engine and segment memory, table of directed
// frames with hand-computed cycle/pixel counts, plus reset and handshake sequences.
module tb_draw_sequencer;

  localparam int FL = 6;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [4:0] len;
    logic [5:0] fx;
    logic [4:0] fy;
    logic [2:0] scol;
    logic [2:0] fcol;
    logic [2:0] bg;
    int         exp_cyc;
    int         exp_pix;
    int         exp_max;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_req;
  logic       frame_done, busy;
  logic [2:0] bg_colour, snake_colour, food_colour;
  logic [4:0] snake_len;
  logic [5:0] food_x;
  logic [4:0] food_y;
  logic [3:0] seg_addr;
  logic [5:0] seg_x;
  logic [4:0] seg_y;
  logic       fill_start;
  logic [2:0] fill_colour_o;
  logic       fill_done;
  logic [7:0] fill_x;
  logic [6:0] fill_y;
  logic [2:0] fill_colour;
  logic       fill_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  logic [5:0] mem_x [16];
  logic [4:0] mem_y [16];
  logic [3:0] fill_cnt = 4'd0;

  pix_t got_q[$];
  pix_t exp_q[$];
  vec_t vecs[6];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  // Stub fill engine: FL pixels, then done held until start drops.
  always @(posedge clk) begin
    if (fill_start !== 1'b1)      fill_cnt <= 4'd0;
    else if (fill_cnt != 4'(FL))  fill_cnt <= fill_cnt + 4'd1;
  end
  assign fill_done   = (fill_cnt == 4'(FL));
  assign fill_plot   = (fill_start === 1'b1) && !fill_done;
  assign fill_x      = {fill_cnt, 4'h3};
  assign fill_y      = {fill_cnt, 3'b101};
  assign fill_colour = fill_cnt[2:0] ^ 3'b101;

  assign seg_x = mem_x[seg_addr];
  assign seg_y = mem_y[seg_addr];

  draw_sequencer #(.MAX_LEN(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_req   (frame_req),
    .o_frame_done  (frame_done),
    .o_busy        (busy),
    .i_bg_colour   (bg_colour),
    .i_snake_colour(snake_colour),
    .i_food_colour (food_colour),
    .i_snake_len   (snake_len),
    .i_food_x      (food_x),
    .i_food_y      (food_y),
    .o_seg_addr    (seg_addr),
    .i_seg_x       (seg_x),
    .i_seg_y       (seg_y),
    .o_fill_start  (fill_start),
    .o_fill_colour (fill_colour_o),
    .i_fill_done   (fill_done),
    .i_fill_x      (fill_x),
    .i_fill_y      (fill_y),
    .i_fill_colour (fill_colour),
    .i_fill_plot   (fill_plot),
    .o_vga_x       (vga_x),
    .o_vga_y       (vga_y),
    .o_vga_colour  (vga_colour),
    .o_vga_plot    (vga_plot)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    else n_pass++;
  endtask

  function automatic void add_cell(input logic [5:0] cx, input logic [4:0] cy,
                                   input logic [2:0] col);
    pix_t p;
    if (cx < 6'd40 && cy < 5'd30) begin
      for (int dy = 0; dy < 4; dy++) begin
        for (int dx = 0; dx < 4; dx++) begin
          p.x = {cx, 2'b00} + 8'(dx);
          p.y = {cy, 2'b00} + 7'(dy);
          p.c = col;
          exp_q.push_back(p);
        end
      end
    end
  endfunction

  task automatic run_frame(input vec_t v, input int k);
    int   t_fall, t_done, cyc, mirror_err, hold_err, col_err, max_addr, mism, done_err, nseg;
    logic pfd, pfs, scrambled;
    pix_t p;
    t_fall = -1; t_done = -1; cyc = 0; mirror_err = 0; hold_err = 0; col_err = 0;
    max_addr = 0; mism = 0; done_err = 0; pfd = 1'b0; pfs = 1'b0; scrambled = 1'b0;
    got_q.delete();
    exp_q.delete();
    snake_len = v.len; food_x = v.fx; food_y = v.fy;
    snake_colour = v.scol; food_colour = v.fcol; bg_colour = v.bg;
    frame_req = 1'b1;
    while (cyc < 3000 && t_done < 0) begin
      @(negedge clk);
      cyc++;
      if (busy && !scrambled) begin
        // Anything but segment memory must be ignored once latched.
        snake_len = 5'd9; food_x = 6'd33; food_y = 5'd17;
        snake_colour = ~v.scol; food_colour = ~v.fcol; bg_colour = ~v.bg;
        scrambled = 1'b1;
      end
      if (fill_start) begin
        if (vga_x !== fill_x || vga_y !== fill_y || vga_colour !== fill_colour ||
            vga_plot !== fill_plot) mirror_err++;
        if (fill_colour_o !== v.bg) col_err++;
      end else if (vga_plot) begin
        p.x = vga_x; p.y = vga_y; p.c = vga_colour;
        got_q.push_back(p);
      end
      if (pfs && !fill_start && !pfd) hold_err++;
      if (pfd && !fill_done && t_fall < 0) t_fall = cyc;
      if (frame_done && t_done < 0) t_done = cyc;
      if (busy && int'(seg_addr) > max_addr) max_addr = int'(seg_addr);
      pfd = fill_done;
      pfs = fill_start;
    end
    check($sformatf("v%0d frame_done reached", k), (t_done >= 0 && t_fall >= 0), 1);
    check($sformatf("v%0d fill_done fall to frame_done", k), t_done - t_fall, v.exp_cyc);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!frame_done || !busy || fill_start || vga_plot) done_err++;
    end
    check($sformatf("v%0d DONE held while frame_req high", k), done_err, 0);
    frame_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d idle after frame_req falls", k), {frame_done, busy}, 0);
    nseg = (v.len > 5'd16) ? 16 : int'(v.len);
    for (int i = 0; i < nseg; i++) add_cell(mem_x[i], mem_y[i], v.scol);
    add_cell(v.fx, v.fy, v.fcol);
    for (int i = 0; i < got_q.size(); i++)
      if (i >= exp_q.size() || got_q[i] !== exp_q[i]) mism++;
    check($sformatf("v%0d plotted pixel count", k), got_q.size(), v.exp_pix);
    check($sformatf("v%0d pixel order/colour", k), mism, 0);
    check($sformatf("v%0d clear mirror", k), mirror_err, 0);
    check($sformatf("v%0d fill_start held to done", k), hold_err, 0);
    check($sformatf("v%0d fill colour latched", k), col_err, 0);
    check($sformatf("v%0d max seg_addr", k), max_addr, v.exp_max);
  endtask

  initial begin
    logic seen;
    mem_x[0] = 6'd39; mem_y[0] = 5'd29;
    mem_x[1] = 6'd1;  mem_y[1] = 5'd0;
    mem_x[2] = 6'd40; mem_y[2] = 5'd3;
    mem_x[3] = 6'd2;  mem_y[3] = 5'd2;
    for (int i = 4; i < 16; i++) begin
      mem_x[i] = 6'(2 * i);
      mem_y[i] = 5'(i);
    end
    //            len    fx     fy     scol  fcol  bg    cyc  pix  max
    vecs[0] = '{5'd0,  6'd0,  5'd0,  3'd2, 3'd5, 3'd1, 17,  16,  0};
    vecs[1] = '{5'd2,  6'd5,  5'd5,  3'd3, 3'd6, 3'd0, 51,  48,  1};
    vecs[2] = '{5'd4,  6'd10, 5'd7,  3'd4, 3'd1, 3'd7, 85,  64,  3};
    vecs[3] = '{5'd20, 6'd39, 5'd29, 3'd7, 3'd2, 3'd3, 289, 256, 15};
    vecs[4] = '{5'd1,  6'd40, 5'd0,  3'd1, 3'd7, 3'd2, 34,  16,  0};
    vecs[5] = '{5'd3,  6'd0,  5'd30, 3'd6, 3'd3, 3'd5, 68,  32,  2};

    rst_n = 1'b0; frame_req = 1'b0; bg_colour = '0; snake_colour = '0; food_colour = '0;
    snake_len = '0; food_x = '0; food_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset frame_done/busy/fill_start", {frame_done, busy, fill_start}, 0);
    check("reset seg_addr", seg_addr, 0);
    check("reset vga_x/vga_y", {vga_x, vga_y}, 0);
    check("reset vga_colour/vga_plot", {vga_colour, vga_plot}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset release", {busy, fill_start, vga_plot}, 0);

    // Start latency, then frame_req dropped mid-frame.
    snake_len = 5'd1; food_x = 6'd3; food_y = 5'd3; bg_colour = 3'd4;
    frame_req = 1'b1;
    #1 check("fill_start low while IDLE", fill_start, 0);
    @(negedge clk);
    check("fill_start one cycle after frame_req", {fill_start, busy}, 2'b11);
    frame_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check("frame completes after mid-frame drop", seen, 1);
    @(negedge clk);
    check("idle after dropped-request frame", {busy, frame_done}, 0);

    for (int k = 0; k < 6; k++) run_frame(vecs[k], k);

    // Reset while plotting a segment.
    snake_len = 5'd2; food_x = 6'd5; food_y = 5'd5;
    frame_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (vga_plot && !fill_start) seen = 1'b1;
    end
    check("reached segment plot before reset", seen, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-plot reset vga_plot", vga_plot, 0);
    check("mid-plot reset fill_start", fill_start, 0);
    check("mid-plot reset busy/frame_done", {busy, frame_done}, 0);
    check("mid-plot reset seg_addr/vga_x", {seg_addr, vga_x}, 0);
    frame_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle after mid-plot reset", {busy, fill_start}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
